bypass_scoreboard_regfile: RTL and testbench
============================================

# bypass_scoreboard_regfile

Parametrised multi-port physical register file with per-entry ready (scoreboard) bits, true same-cycle write-to-read bypass, allocation ports that mark entries pending, and a registered write-collision flag. It sits between rename/dispatch and the issue/execute stages. Rename clears ready bits through the allocation ports. Writeback ports deliver results. Issue reads operands and readiness through the read ports.

## Interface
Parameters:
- SELECT_WIDTH, 6, width of every entry select
- DATA_WIDTH, 32, width of each entry
- COUNT, 64, number of entries; must be ≤ 2^SELECT_WIDTH; entry 0 is hard-wired zero
- NUM_WRITE_PORT, 2, writeback ports
- NUM_READ_PORT, 6, read ports
- NUM_ALLOC_PORT, 2, allocation (ready-clear) ports

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- alloc_enb  in  1 [NUM_ALLOC_PORT]  allocate entry (clear ready)
- alloc_sel  in  SELECT_WIDTH [NUM_ALLOC_PORT]  entry to allocate
- w_enb  in  1 [NUM_WRITE_PORT]  write enable
- w_sel  in  SELECT_WIDTH [NUM_WRITE_PORT]  write entry
- w_val  in  DATA_WIDTH [NUM_WRITE_PORT]  write data
- r_sel  in  SELECT_WIDTH [NUM_READ_PORT]  read entry
- r_val  out  DATA_WIDTH [NUM_READ_PORT]  read data (bypassed)
- r_ready  out  1 [NUM_READ_PORT]  entry ready (bypassed)
- w_conflict  out  1  registered pulse: colliding writes occurred last cycle

## Operation
- Storage: data[COUNT], ready[COUNT].
- Write: at the posedge, each enabled port i with w_sel[i] != 0 sets data[w_sel[i]] <= w_val[i] and ready[w_sel[i]] <= 1.
- Allocate: each enabled port j with alloc_sel[j] != 0 sets ready[alloc_sel[j]] <= 0 at the posedge. Data is untouched.
- Priority:
  - Among write ports hitting the same entry, the highest index wins for data.
  - When alloc and write hit the same entry in the same cycle, data is written but ready ends at 0, because alloc wins on ready.
  - Among alloc ports, duplicates are harmless.
- Entry 0:
  - Writes and allocs to it are ignored.
  - Reads return data 0 and ready 1.
- Read (combinational), for port k with r_sel[k] = s:
  - If s == 0: r_val = 0, r_ready = 1.
  - Else, if any enabled write port targets s in this cycle: r_val = w_val of the highest such index, r_ready = 1. This is the bypass, and it ignores a same-cycle alloc.
  - Else: r_val = data[s], r_ready = ready[s].
- Out-of-range select (≥ COUNT):
  - Reads return 0 with ready 0.
  - Writes and allocs to it are ignored.
- Conflict detection:
  - w_conflict <= 1 at the posedge if two or more enabled write ports share the same nonzero, in-range w_sel.
  - Otherwise w_conflict <= 0.
- Reset (rst high, any time, asynchronous):
  - All data clears to 0, all ready bits set to 1, w_conflict = 0.
  - While rst is high, the bypass is disabled: r_val = 0 and r_ready = 1 for every port.
  - Writes and allocs presented during reset are dropped.

## Timing
- Read path is fully combinational from r_sel, w_enb, w_sel and w_val. A write is visible on a read port in the same cycle it is presented, and from storage in every later cycle.
- Allocation affects r_ready from the cycle after alloc_enb is sampled. In the alloc cycle itself, the read returns the pre-alloc ready value.
- w_conflict has one-cycle latency and is high for exactly one cycle per colliding cycle.
- Reset deassertion takes effect at the next posedge. The first write is accepted on the first posedge after rst falls.
- Reset values: r_val = 0, r_ready = 1 on all ports, w_conflict = 0.

## Test plan
- Reset/zero entry:
  - Assert rst mid-run after writing 0xDEADBEEF to entry 5.
  - All reads are 0 with ready 1 immediately, without waiting for a clock edge.
  - Writing 0x1234 to entry 0 and reading entry 0 returns 0, ready 1.
- Bypass:
  - Write 0xA5A5A5A5 to entry 7 on port 0 while read port 3 selects 7 in the same cycle. r_val[3] = 0xA5A5A5A5, r_ready[3] = 1 in that cycle.
  - With no write in the next cycle, the read still returns 0xA5A5A5A5.
- Scoreboard:
  - Alloc entry 9; next cycle r_ready for 9 = 0.
  - Write 0x55 to entry 9 two cycles later: r_ready = 1 in the write cycle via bypass, and stays 1 afterwards.
- Alloc+write same entry:
  - Alloc 12 and write 0x77 to 12 in the same cycle.
  - Next cycle, read 12 gives r_val = 0x77, r_ready = 0.
- Write collision:
  - Ports 0 and 1 write 0x11 and 0x22 to entry 20 in the same cycle.
  - Same-cycle bypass read returns 0x22, and a read of 20 in the next cycle also returns 0x22.
  - w_conflict = 1 for exactly the one cycle after; ports writing entries 20 and 21 give w_conflict = 0.
- Full sweep:
  - Write i*3 to entries 1..COUNT-1, then read all entries through every read port in parallel. Each returns i*3 with ready 1.
  - A select of COUNT (when COUNT < 2^SELECT_WIDTH) returns 0 with ready 0.

Source files
------------

// File: rtl/bypass_scoreboard_regfile.sv
// Multi-port physical register file with per-entry ready (scoreboard) bits.
// Writeback ports store data and set ready. Allocation ports clear ready.
// Read ports see same-cycle writes through a combinational bypass.
// Entry 0 is hard-wired zero/ready. Selects at or above COUNT read as 0/not-ready
// and are ignored for writes and allocs.
// There is no valid/ready handshake: every enabled port is accepted every cycle.
module bypass_scoreboard_regfile #(
    parameter int SELECT_WIDTH   = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int COUNT          = 64,
    parameter int NUM_WRITE_PORT = 2,
    parameter int NUM_READ_PORT  = 6,
    parameter int NUM_ALLOC_PORT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc_enb [NUM_ALLOC_PORT],
    input  logic [SELECT_WIDTH-1:0] alloc_sel [NUM_ALLOC_PORT],
    input  logic                    w_enb     [NUM_WRITE_PORT],
    input  logic [SELECT_WIDTH-1:0] w_sel     [NUM_WRITE_PORT],
    input  logic [DATA_WIDTH-1:0]   w_val     [NUM_WRITE_PORT],
    input  logic [SELECT_WIDTH-1:0] r_sel     [NUM_READ_PORT],
    output logic [DATA_WIDTH-1:0]   r_val     [NUM_READ_PORT],
    output logic                    r_ready   [NUM_READ_PORT],
    output logic                    w_conflict
);

    // One extra bit so COUNT == 2^SELECT_WIDTH is representable.
    localparam logic [SELECT_WIDTH:0] COUNT_W = (SELECT_WIDTH + 1)'(COUNT);

    // A select names a real storage entry: nonzero and below COUNT.
    function automatic logic sel_valid(input logic [SELECT_WIDTH-1:0] s);
        return (s != '0) && ({1'b0, s} < COUNT_W);
    endfunction

    // Storage only exists for entries 1..COUNT-1; entry 0 is synthesised.
    logic [DATA_WIDTH-1:0] data_q  [1:COUNT-1];
    logic                  ready_q [1:COUNT-1];

    logic w_act [NUM_WRITE_PORT];
    logic a_act [NUM_ALLOC_PORT];
    logic conflict_d;

    // Qualify write ports: enabled and aimed at a real entry.
    always_comb begin
        for (int i = 0; i < NUM_WRITE_PORT; i++) begin
            w_act[i] = w_enb[i] && sel_valid(w_sel[i]);
        end
    end

    // Qualify alloc ports the same way.
    always_comb begin
        for (int j = 0; j < NUM_ALLOC_PORT; j++) begin
            a_act[j] = alloc_enb[j] && sel_valid(alloc_sel[j]);
        end
    end

    // Storage update: later write ports override earlier ones for data,
    // and allocs are applied last so they win on the ready bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 1; e < COUNT; e++) begin
                data_q[e]  <= '0;
                ready_q[e] <= 1'b1;
            end
        end else begin
            for (int e = 1; e < COUNT; e++) begin
                for (int i = 0; i < NUM_WRITE_PORT; i++) begin
                    if (w_act[i] && (w_sel[i] == SELECT_WIDTH'(e))) begin
                        data_q[e]  <= w_val[i];
                        ready_q[e] <= 1'b1;
                    end
                end
                for (int j = 0; j < NUM_ALLOC_PORT; j++) begin
                    if (a_act[j] && (alloc_sel[j] == SELECT_WIDTH'(e))) begin
                        ready_q[e] <= 1'b0;
                    end
                end
            end
        end
    end

    // Collision detect: any pair of qualified write ports on the same entry.
    always_comb begin
        conflict_d = 1'b0;
        for (int i = 0; i < NUM_WRITE_PORT; i++) begin
            for (int j = i + 1; j < NUM_WRITE_PORT; j++) begin
                if (w_act[i] && w_act[j] && (w_sel[i] == w_sel[j])) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    // Register the collision flag as a one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_conflict <= 1'b0;
        end else begin
            w_conflict <= conflict_d;
        end
    end

    for (genvar k = 0; k < NUM_READ_PORT; k++) begin : g_read
        logic                  byp_hit;
        logic [DATA_WIDTH-1:0] byp_val;
        logic [DATA_WIDTH-1:0] st_val;
        logic                  st_rdy;

        // Bypass: highest-index qualified write port hitting this select.
        always_comb begin
            byp_hit = 1'b0;
            byp_val = '0;
            for (int i = 0; i < NUM_WRITE_PORT; i++) begin
                if (w_act[i] && (w_sel[i] == r_sel[k])) begin
                    byp_hit = 1'b1;
                    byp_val = w_val[i];
                end
            end
        end

        // Storage lookup for this read port.
        always_comb begin
            st_val = '0;
            st_rdy = 1'b0;
            for (int e = 1; e < COUNT; e++) begin
                if (r_sel[k] == SELECT_WIDTH'(e)) begin
                    st_val = data_q[e];
                    st_rdy = ready_q[e];
                end
            end
        end

        // Reset forces 0/ready; entry 0 reads 0/ready; out-of-range reads 0/not-ready.
        assign r_val[k]   = (rst || !sel_valid(r_sel[k])) ? '0
                          : (byp_hit ? byp_val : st_val);
        assign r_ready[k] = rst || (r_sel[k] == '0)
                          || (sel_valid(r_sel[k]) && (byp_hit || st_rdy));
    end

endmodule

// File: tb/tb_bypass_scoreboard_regfile.sv
// Bench for bypass_scoreboard_regfile: directed corner sequences, a vector
// table, and random traffic checked against a behavioural register model.
module tb_bypass_scoreboard_regfile;

  localparam int SW    = 6;
  localparam int DW    = 32;
  localparam int COUNT = 40;
  localparam int NW    = 2;
  localparam int NR    = 6;
  localparam int NA    = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          alloc_enb [NA];
  logic [SW-1:0] alloc_sel [NA];
  logic          w_enb     [NW];
  logic [SW-1:0] w_sel     [NW];
  logic [DW-1:0] w_val     [NW];
  logic [SW-1:0] r_sel     [NR];
  logic [DW-1:0] r_val     [NR];
  logic          r_ready   [NR];
  logic          w_conflict;

  bypass_scoreboard_regfile #(
    .SELECT_WIDTH(SW), .DATA_WIDTH(DW), .COUNT(COUNT),
    .NUM_WRITE_PORT(NW), .NUM_READ_PORT(NR), .NUM_ALLOC_PORT(NA)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc_enb(alloc_enb), .alloc_sel(alloc_sel),
    .w_enb(w_enb), .w_sel(w_sel), .w_val(w_val),
    .r_sel(r_sel), .r_val(r_val), .r_ready(r_ready),
    .w_conflict(w_conflict)
  );

  int total = 0;
  int bad   = 0;

  // reference model: plain arrays indexed by entry number
  logic [DW-1:0] m_data  [2**SW];
  logic          m_ready [2**SW];
  logic          m_conf;

  // scoreboard queue of {ready, value}
  logic [DW:0] exp_q [$];

  task automatic chk(input string name, input logic [DW:0] got, input logic [DW:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int e = 0; e < 2**SW; e++) begin
      m_data[e]  = '0;
      m_ready[e] = 1'b1;
    end
    m_conf = 1'b0;
  endtask

  function automatic logic [DW:0] model_read(input logic [SW-1:0] s);
    logic [DW:0] res;
    if (rst || s == 0) return {1'b1, {DW{1'b0}}};
    if (int'(s) >= COUNT) return {1'b0, {DW{1'b0}}};
    res = {m_ready[s], m_data[s]};
    for (int i = 0; i < NW; i++)
      if (w_enb[i] && w_sel[i] == s) res = {1'b1, w_val[i]};
    return res;
  endfunction

  // what one clock edge does to the model (inputs as seen before the edge)
  task automatic model_clock();
    m_conf = 1'b0;
    for (int i = 0; i < NW; i++)
      for (int j = 0; j < NW; j++)
        if (i != j && w_enb[i] && w_enb[j] && w_sel[i] == w_sel[j]
            && w_sel[i] != 0 && int'(w_sel[i]) < COUNT) m_conf = 1'b1;
    for (int i = 0; i < NW; i++)
      if (w_enb[i] && w_sel[i] != 0 && int'(w_sel[i]) < COUNT) begin
        m_data[w_sel[i]]  = w_val[i];
        m_ready[w_sel[i]] = 1'b1;
      end
    for (int j = 0; j < NA; j++)
      if (alloc_enb[j] && alloc_sel[j] != 0 && int'(alloc_sel[j]) < COUNT)
        m_ready[alloc_sel[j]] = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    logic [DW:0] e;
    for (int k = 0; k < NR; k++) exp_q.push_back(model_read(r_sel[k]));
    for (int k = 0; k < NR; k++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s_rd%0d_sel%0d", tag, k, r_sel[k]), {r_ready[k], r_val[k]}, e);
    end
    chk({tag, "_conflict"}, {{DW{1'b0}}, w_conflict}, {{DW{1'b0}}, m_conf});
  endtask

  // driver tasks
  task automatic idle();
    for (int i = 0; i < NW; i++) begin w_enb[i] = 0; w_sel[i] = '0; w_val[i] = '0; end
    for (int j = 0; j < NA; j++) begin alloc_enb[j] = 0; alloc_sel[j] = '0; end
    for (int k = 0; k < NR; k++) r_sel[k] = '0;
  endtask

  task automatic tick(input string tag);
    #1;
    check_outputs(tag);
    @(posedge clk);
    if (!rst) model_clock();
    #1;
  endtask

  task automatic rd(input string name, input int k, input logic [DW-1:0] v, input logic r);
    chk(name, {r_ready[k], r_val[k]}, {r, v});
  endtask

  typedef struct {
    logic          we;
    logic [SW-1:0] ws;
    logic [DW-1:0] wv;
    logic          ae;
    logic [SW-1:0] as;
    logic [SW-1:0] rs;
    logic [DW-1:0] ev;
    logic          er;
  } vec_t;
  vec_t vecs [11];

  initial begin
    // table assumes the state left by the full sweep (entry i holds i*3)
    vecs[0]  = '{0, 0,  0,          0, 0,  0,  32'd0,   1};
    vecs[1]  = '{0, 0,  0,          0, 0,  5,  32'd15,  1};
    vecs[2]  = '{0, 0,  0,          0, 0,  39, 32'd117, 1};
    vecs[3]  = '{0, 0,  0,          0, 0,  40, 32'd0,   0};
    vecs[4]  = '{1, 11, 32'hABC,    0, 0,  11, 32'hABC, 1};
    vecs[5]  = '{0, 0,  0,          0, 0,  11, 32'hABC, 1};
    vecs[6]  = '{0, 0,  0,          1, 11, 11, 32'hABC, 1};
    vecs[7]  = '{0, 0,  0,          0, 0,  11, 32'hABC, 0};
    vecs[8]  = '{1, 0,  32'h1234,   0, 0,  0,  32'd0,   1};
    vecs[9]  = '{1, 40, 32'h99,     0, 0,  40, 32'd0,   0};
    vecs[10] = '{1, 63, 32'h77,     1, 63, 63, 32'd0,   0};

    // power-on reset
    rst = 1'b1;
    idle();
    model_reset();
    #12;
    check_outputs("por");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // mid-run reset after writing entry 5
    w_enb[0] = 1; w_sel[0] = 5; w_val[0] = 32'hDEADBEEF;
    tick("wr5");
    idle();
    for (int k = 0; k < NR; k++) r_sel[k] = 5;
    #1;
    rd("pre_rst_rd5", 0, 32'hDEADBEEF, 1);
    #2;
    rst = 1'b1;
    model_reset();
    w_enb[0] = 1; w_sel[0] = 5; w_val[0] = 32'hCAFE;
    #1;
    for (int k = 0; k < NR; k++) rd($sformatf("rst_rd%0d", k), k, 32'd0, 1);
    tick("in_rst");
    rst = 1'b0;
    idle();
    w_enb[0] = 1; w_sel[0] = 0; w_val[0] = 32'h1234;
    r_sel[0] = 0; r_sel[1] = 5;
    #1;
    rd("zero_rd", 0, 32'd0, 1);
    rd("post_rst_rd5", 1, 32'd0, 1);
    tick("wr0");

    // bypass
    idle();
    w_enb[0] = 1; w_sel[0] = 7; w_val[0] = 32'hA5A5A5A5; r_sel[3] = 7;
    #1;
    rd("byp7", 3, 32'hA5A5A5A5, 1);
    tick("byp7");
    idle();
    r_sel[3] = 7;
    #1;
    rd("stor7", 3, 32'hA5A5A5A5, 1);
    tick("stor7");

    // scoreboard: alloc 9, write two cycles later
    idle();
    alloc_enb[0] = 1; alloc_sel[0] = 9;
    tick("alloc9");
    idle();
    r_sel[0] = 9;
    #1;
    rd("pend9", 0, 32'd0, 0);
    tick("pend9");
    w_enb[1] = 1; w_sel[1] = 9; w_val[1] = 32'h55;
    #1;
    rd("byp9", 0, 32'h55, 1);
    tick("byp9");
    idle();
    r_sel[0] = 9;
    #1;
    rd("rdy9", 0, 32'h55, 1);
    tick("rdy9");

    // alloc and write to the same entry
    idle();
    alloc_enb[1] = 1; alloc_sel[1] = 12;
    w_enb[0] = 1; w_sel[0] = 12; w_val[0] = 32'h77;
    r_sel[2] = 12;
    #1;
    rd("aw12_byp", 2, 32'h77, 1);
    tick("aw12");
    idle();
    r_sel[2] = 12;
    #1;
    rd("aw12_after", 2, 32'h77, 0);
    tick("aw12_after");

    // write collision
    idle();
    w_enb[0] = 1; w_sel[0] = 20; w_val[0] = 32'h11;
    w_enb[1] = 1; w_sel[1] = 20; w_val[1] = 32'h22;
    r_sel[4] = 20;
    #1;
    rd("coll_byp", 4, 32'h22, 1);
    chk("coll_flag_same", {{DW{1'b0}}, w_conflict}, '0);
    tick("coll");
    idle();
    r_sel[4] = 20;
    #1;
    rd("coll_stor", 4, 32'h22, 1);
    chk("coll_flag_pulse", {{DW{1'b0}}, w_conflict}, {{DW{1'b0}}, 1'b1});
    w_enb[0] = 1; w_sel[0] = 20; w_val[0] = 32'h1;
    w_enb[1] = 1; w_sel[1] = 21; w_val[1] = 32'h2;
    tick("nocoll");
    idle();
    #1;
    chk("coll_flag_off", {{DW{1'b0}}, w_conflict}, '0);
    tick("nocoll_after");

    // full sweep: entry i <- i*3, two entries per cycle
    for (int i = 1; i < COUNT; i += 2) begin
      idle();
      w_enb[0] = 1; w_sel[0] = SW'(i); w_val[0] = DW'(i * 3);
      if (i + 1 < COUNT) begin
        w_enb[1] = 1; w_sel[1] = SW'(i + 1); w_val[1] = DW'((i + 1) * 3);
      end
      tick("sweep_wr");
    end
    for (int base = 0; base <= COUNT; base += NR) begin
      idle();
      for (int k = 0; k < NR; k++) r_sel[k] = SW'(base + k);
      #1;
      for (int k = 0; k < NR; k++) begin
        if (base + k < COUNT) rd($sformatf("sweep_rd%0d", base + k), k, DW'((base + k) * 3), 1);
        else rd($sformatf("sweep_oor%0d", base + k), k, 32'd0, 0);
      end
      tick("sweep_rd");
    end

    // vector table
    for (int v = 0; v < 11; v++) begin
      idle();
      w_enb[0] = vecs[v].we; w_sel[0] = vecs[v].ws; w_val[0] = vecs[v].wv;
      alloc_enb[0] = vecs[v].ae; alloc_sel[0] = vecs[v].as;
      r_sel[2] = vecs[v].rs;
      #1;
      rd($sformatf("vec%0d", v), 2, vecs[v].ev, vecs[v].er);
      tick($sformatf("vec%0d", v));
    end

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int i = 0; i < NW; i++) begin
        w_enb[i] = 1'($urandom_range(0, 1));
        w_sel[i] = SW'($urandom_range(0, 47));
        w_val[i] = $urandom;
      end
      for (int j = 0; j < NA; j++) begin
        alloc_enb[j] = 1'($urandom_range(0, 1));
        alloc_sel[j] = SW'($urandom_range(0, 47));
      end
      for (int k = 0; k < NR; k++) begin
        r_sel[k] = (k < NW && $urandom_range(0, 1) == 1) ? w_sel[k] : SW'($urandom_range(0, 47));
      end
      tick("rand");
    end
    idle();
    tick("final");

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
